// File: rtl/gpio_frame_sequencer.sv
// gpio_frame_sequencer
//
// Frame-level controller for the Processor's GPIO pixel output port.
// A start request runs the Processor reset/init sequence. It then holds
// proc_swinit while the GPIO pixels strobed by pix_valid are captured into
// a small first-word-fall-through FIFO and counted. Once PIXEL_COUNT pixels
// have been seen, the FIFO is drained to the consumer and done is raised.
//
// Optional feature: define GPIO_SEQ_TIMEOUT_EN to build an idle watchdog in
// RUN. After TIMEOUT_CYCLES cycles without a strobe it sets timeout and
// forces the drain. Without the macro, timeout is tied low.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   frame request, honoured only in IDLE or DONE
//   proc_reset   out  reset to Processor (high in RST)
//   proc_swinit  out  swinit to Processor (high in RUN)
//   pix_in       in   Processor GPIO pixel data
//   pix_valid    in   Processor GPIOBoolean strobe, one pixel per high cycle
//   out_data     out  FIFO head (0 when empty)
//   out_valid    out  FIFO non-empty
//   out_ready    in   consumer accept
//   pix_cnt      out  pixels counted this frame
//   busy         out  high in RST, RUN, DRAIN
//   done         out  high in DONE
//   overflow     out  sticky, a pixel was dropped this frame
//   timeout      out  sticky watchdog flag
//   state_dbg    out  current FSM state encoding
//
// Handshake: a word leaves the FIFO in every cycle where out_valid and
// out_ready are both high. out_data is stable while out_valid is high and
// out_ready is low. The producer side has no backpressure. A pixel that
// finds the FIFO full, with no pop in the same cycle, is dropped.

module gpio_frame_sequencer #(
    parameter int PIXEL_COUNT    = 27360,
    parameter int PIXEL_W        = 1,
    parameter int FIFO_DEPTH     = 16,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             proc_reset,
    output logic                             proc_swinit,
    input  logic [PIXEL_W-1:0]               pix_in,
    input  logic                             pix_valid,
    output logic [PIXEL_W-1:0]               out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(PIXEL_COUNT+1)-1:0] pix_cnt,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic                             timeout,
    output logic [2:0]                       state_dbg
);

    localparam int CW = $clog2(PIXEL_COUNT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0] LAST_PIX = CW'(PIXEL_COUNT - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [AW:0]   ONE_WORD = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [PIXEL_W-1:0] mem [FIFO_DEPTH];
    // The extra top pointer bit separates full from empty when the index bits match.
    logic [AW:0]        wr_ptr, rd_ptr, fill;
    logic [RW-1:0]      rst_cnt;
    logic               empty, full, pop, push, drop;
    logic               enter_rst, frame_end, last_pop, timeout_hit;

    assign fill      = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept a pixel.
    assign push      = (state == S_RUN) && pix_valid && (!full || pop);
    assign drop      = (state == S_RUN) && pix_valid && full && !pop;
    assign frame_end = (state == S_RUN) && pix_valid && (pix_cnt == LAST_PIX);
    assign enter_rst = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign last_pop  = pop && (fill == ONE_WORD);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RST;
            S_RST:   if (rst_cnt == RST_LAST) state_next = S_RUN;
            S_RUN:   if (frame_end || timeout_hit) state_next = S_DRAIN;
            S_DRAIN: if (empty || last_pop) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_RST;
            default: state_next = S_IDLE;
        endcase
    end

    assign proc_reset  = (state == S_RST);
    assign proc_swinit = (state == S_RUN);
    assign busy        = (state == S_RST) || (state == S_RUN) || (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign out_valid   = !empty;
    assign out_data    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign state_dbg   = state;

    // Reset-phase cycle counter, idle at zero outside RST
    always_ff @(posedge clk) begin
        if (reset || (state != S_RST)) rst_cnt <= '0;
        else                           rst_cnt <= rst_cnt + RW'(1);
    end

    // FIFO pointers; starting a frame flushes anything left behind
    always_ff @(posedge clk) begin
        if (reset || enter_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE_WORD;
            if (pop)  rd_ptr <= rd_ptr + ONE_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= pix_in;
    end

    // Frame pixel count and drop flag; dropped pixels still count
    always_ff @(posedge clk) begin
        if (reset || enter_rst) begin
            pix_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if ((state == S_RUN) && pix_valid) pix_cnt <= pix_cnt + CW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef GPIO_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_cnt;
    logic          timeout_q;

    // Counts cycles since the last strobe or since RUN entry
    assign timeout_hit = (state == S_RUN) && !pix_valid && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (reset || (state != S_RUN) || pix_valid) idle_cnt <= '0;
        else                                        idle_cnt <= idle_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || enter_rst) timeout_q <= 1'b0;
        else if (timeout_hit)   timeout_q <= 1'b1;
    end

    assign timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_frame_sequencer.sv
// tb_gpio_frame_sequencer
//
// Self-checking bench for gpio_frame_sequencer with PIXEL_COUNT=8,
// FIFO_DEPTH=4 and RST_CYCLES=2. A frame-level reference model keeps the
// frame phase, the pixel count, the drop flag and the FIFO contents as a
// queue. Every cycle the DUT outputs are compared against that model.
// Inputs change 1 ns after the rising edge and outputs are sampled at the
// same point.

module tb_gpio_frame_sequencer;

    localparam int PC = 8;
    localparam int FD = 4;
    localparam int RC = 2;
    localparam int PW = 1;
    localparam int CW = $clog2(PC + 1);

    localparam int P_IDLE  = 0;
    localparam int P_RST   = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [PW-1:0] pix_in;
    logic          pix_valid;
    logic          out_ready;
    logic          proc_reset, proc_swinit, out_valid, busy, done, overflow, timeout;
    logic [PW-1:0] out_data;
    logic [CW-1:0] pix_cnt;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    gpio_frame_sequencer #(
        .PIXEL_COUNT(PC), .PIXEL_W(PW), .FIFO_DEPTH(FD),
        .RST_CYCLES(RC), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .proc_reset(proc_reset), .proc_swinit(proc_swinit),
        .pix_in(pix_in), .pix_valid(pix_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .pix_cnt(pix_cnt), .busy(busy), .done(done),
        .overflow(overflow), .timeout(timeout), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    int            m_phase, m_rst_left, m_cnt;
    bit            m_ovf;
    logic [PW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("proc_reset", 32'(proc_reset), 32'(m_phase == P_RST));
        chk("proc_swinit", 32'(proc_swinit), 32'(m_phase == P_RUN));
        chk("busy", 32'(busy), 32'(m_phase == P_RST || m_phase == P_RUN || m_phase == P_DRAIN));
        chk("done", 32'(done), 32'(m_phase == P_DONE));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
        chk("pix_cnt", 32'(pix_cnt), 32'(m_cnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("timeout", 32'(timeout), 32'(0));
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: apply inputs, check outputs, advance the model, step the clock.
    task automatic cyc(input bit st, input bit pv, input logic [PW-1:0] pin, input bit rdy);
        bit popped;
        start     = st;
        pix_valid = pv;
        pix_in    = pin;
        out_ready = rdy;
        check_outputs();
        popped = (exp_q.size() != 0) && rdy;
        if (popped) void'(exp_q.pop_front());
        case (m_phase)
            P_IDLE, P_DONE: if (st) begin
                m_phase    = P_RST;
                m_rst_left = RC;
                m_cnt      = 0;
                m_ovf      = 1'b0;
                exp_q.delete();
            end
            P_RST: begin
                m_rst_left--;
                if (m_rst_left == 0) m_phase = P_RUN;
            end
            P_RUN: if (pv) begin
                m_cnt++;
                if (exp_q.size() < FD) exp_q.push_back(pin);
                else                   m_ovf = 1'b1;
                if (m_cnt == PC) m_phase = P_DRAIN;
            end
            P_DRAIN: if (exp_q.size() == 0) m_phase = P_DONE;
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_proc_reset", 32'(proc_reset), 32'(0));
        chk("rst_proc_swinit", 32'(proc_swinit), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_pix_cnt", 32'(pix_cnt), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_timeout", 32'(timeout), 32'(0));
        reset      = 1'b0;
        m_phase    = P_IDLE;
        m_rst_left = 0;
        m_cnt      = 0;
        m_ovf      = 1'b0;
        exp_q.delete();
    endtask

    // Issue start and run through the reset phase into RUN.
    task automatic to_run(input bit rdy);
        int g;
        cyc(1'b1, 1'b0, '0, rdy);
        g = 0;
        while (m_phase != P_RUN && g < 10) begin
            cyc(1'b0, 1'b0, '0, rdy);
            g++;
        end
        if (m_phase != P_RUN) chk("to_run_budget", 32'(0), 32'(1));
    endtask

    // Random traffic until the frame completes, bounded by a cycle budget.
    task automatic wait_done(input int budget, input bit rand_ready);
        int g;
        g = 0;
        while (m_phase != P_DONE && g < budget) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                PW'($urandom_range(0, 1)),
                rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
            g++;
        end
        if (m_phase != P_DONE) chk("wait_done_budget", 32'(0), 32'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Clean frame: alternating 1/0 pixels with the consumer always ready.
        to_run(1'b1);
        for (int i = 0; i < PC; i++) cyc(1'b0, 1'b1, PW'((i % 2) == 0), 1'b1);
        wait_done(50, 1'b0);
        chk("f1_pix_cnt", 32'(pix_cnt), 32'(PC));
        chk("f1_done", 32'(done), 32'(1));
        chk("f1_overflow", 32'(overflow), 32'(0));

        // Stalled consumer: 6 back-to-back strobes, only 4 fit.
        to_run(1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, PW'($urandom_range(0, 1)), 1'b0);
        chk("f2_overflow", 32'(overflow), 32'(1));
        chk("f2_pix_cnt", 32'(pix_cnt), 32'(6));
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, PW'($urandom_range(0, 1)), 1'b1);
        wait_done(50, 1'b0);
        chk("f2_done", 32'(done), 32'(1));

        // Full FIFO, then a push with a simultaneous pop.
        to_run(1'b0);
        for (int i = 0; i < FD; i++) cyc(1'b0, 1'b1, PW'($urandom_range(0, 1)), 1'b0);
        cyc(1'b0, 1'b1, PW'($urandom_range(0, 1)), 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("f3_overflow", 32'(overflow), 32'(0));
        chk("f3_out_valid", 32'(out_valid), 32'(1));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, PW'($urandom_range(0, 1)), 1'b1);
        wait_done(50, 1'b0);
        chk("f3_pix_cnt", 32'(pix_cnt), 32'(PC));

        // Reset in the middle of RUN, then a clean frame.
        to_run(1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, PW'($urandom_range(0, 1)), 1'b0);
        chk("f4_pix_cnt_mid", 32'(pix_cnt), 32'(3));
        do_reset();
        to_run(1'b1);
        for (int i = 0; i < PC; i++) cyc(1'b0, 1'b1, PW'($urandom_range(0, 1)), 1'b1);
        wait_done(50, 1'b0);
        chk("f5_overflow", 32'(overflow), 32'(0));

        // Random frames: random strobes, ready and stray start pulses.
        for (int f = 0; f < 12; f++) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) cyc(1'b0, 1'b0, '0, 1'b1);
            cyc(1'b1, 1'b0, '0, ($urandom_range(0, 1) != 0));
            wait_done(400, 1'b1);
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

endmodule

// File: doc/gpio_frame_sequencer.md
Name: gpio_frame_sequencer

Overview:
- Frame-level controller for the Processor's GPIO pixel output port.
- On a start request it runs the Processor's reset and init sequence, then holds `proc_swinit`.
- Captures each GPIO pixel strobed by `GPIOBoolean` into a small FIFO and counts pixels until a full frame (`PIXEL_COUNT`) has been emitted.
- Drains the FIFO to a downstream consumer (frame writer / display path) over a valid/ready handshake, then signals done.

Parameters:
- PIXEL_COUNT, 27360, pixels per frame; frame ends after this many `pix_valid` strobes.
- PIXEL_W, 1, width of GPIO pixel data.
- FIFO_DEPTH, 16, entries in the capture FIFO; power of two, ≥2.
- RST_CYCLES, 2, cycles `proc_reset` is held high before init.
- TIMEOUT_CYCLES, 4096, idle-strobe limit (optional feature only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE or DONE.
- proc_reset  out  1  reset to Processor.
- proc_swinit  out  1  swinit to Processor; level, held through RUN.
- pix_in  in  PIXEL_W  Processor GPIO data.
- pix_valid  in  1  Processor GPIOBoolean strobe; one pixel per high cycle.
- out_data  out  PIXEL_W  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts `out_data` when `out_valid & out_ready`.
- pix_cnt  out  $clog2(PIXEL_COUNT+1)  pixels counted this frame (15 bits at default).
- busy  out  1  high in RST, RUN, DRAIN.
- done  out  1  high in DONE.
- overflow  out  1  sticky: a pixel was dropped this frame.
- timeout  out  1  sticky watchdog flag; constant 0 when feature is disabled.

Behaviour:
- Reset:
  - State IDLE; FIFO flushed.
  - `pix_cnt`, `proc_reset`, `proc_swinit`, `out_valid`, `busy`, `done`, `overflow` and `timeout` are all 0.
  - `out_data` is 0.
  - Reset asserted mid-frame aborts immediately to the same condition.
- States: IDLE, RST, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 → RST next cycle.
  - Entering RST clears `pix_cnt`, `overflow` and `timeout`, and flushes the FIFO.
- RST:
  - `proc_reset`=1 for exactly RST_CYCLES cycles, then → RUN.
  - `proc_swinit`=0 throughout.
- RUN:
  - `proc_swinit`=1.
  - Each cycle with `pix_valid`=1 increments `pix_cnt`.
  - Pixel is pushed if FIFO not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the pixel is dropped, `overflow` is set, and it is still counted.
  - When the increment makes `pix_cnt`==PIXEL_COUNT → DRAIN next cycle, and `proc_swinit` drops in that cycle.
- DRAIN:
  - `pix_valid` is ignored: not counted, not pushed.
  - Once FIFO is empty (after a pop or already empty) → DONE next cycle.
- DONE:
  - `done`=1; `pix_cnt` holds PIXEL_COUNT.
  - `start`=1 → RST (new frame).
- `start` in RST, RUN or DRAIN is ignored.
- FIFO latency: pixel pushed in cycle N appears with `out_valid`=1 in cycle N+1.
  - Data is first-word-fall-through at the head; pop = `out_valid & out_ready`.
  - `out_data` holds stable while `out_valid & !out_ready`.
  - Read/write pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
  - Pop from empty is a no-op.
- Consumer may drain during RUN; `out_ready` may toggle arbitrarily.

Optional Feature:
- Macro: `GPIO_SEQ_TIMEOUT_EN`.
- When defined:
  - An idle counter in RUN counts cycles since the last `pix_valid` (or since RUN entry).
  - Reaching TIMEOUT_CYCLES sets `timeout`, drops `proc_swinit` and forces → DRAIN.
  - `pix_cnt` holds the partial count.
- When undefined: no counter is built, `timeout` is tied 0, and RUN waits indefinitely.

Test Plan (PIXEL_COUNT=8, FIFO_DEPTH=4, RST_CYCLES=2, `out_ready`=1):
- Reset then `start` pulse → `proc_reset` high exactly 2 cycles, then `proc_swinit`=1; `busy`=1 from the cycle after `start`.
- 8 strobes of alternating 1/0 → `out_data` stream 1,0,1,0,1,0,1,0, each 1 cycle after its push.
  - `pix_cnt`=8, `proc_swinit` drops, `done`=1 once FIFO empty, `overflow`=0.
- `out_ready`=0 with 6 back-to-back strobes → 4 stored, 2 dropped, `overflow`=1, `pix_cnt`=6.
  - Releasing ready yields the first 4 pixels in order.
- FIFO full plus a push with a simultaneous pop → push accepted, occupancy stays 4, `overflow` stays 0.
- Assert `reset` mid-RUN at `pix_cnt`=3 → next cycle IDLE, all outputs 0, `out_valid`=0.
  - A new `start` runs a clean 8-pixel frame.
- With `GPIO_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=16, 3 strobes then silence → `timeout`=1 on the 16th idle cycle.
  - FIFO drains, `done`=1, `pix_cnt`=3.
